// File: rtl/huffman_pkg.sv
// huffman_pkg: shared state/error types and sizing helpers for the Huffman code generator.
package huffman_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_MERGE, S_WALK, S_WR, S_DONE} state_t;
   typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_EMPTY = 2'b01, ERR_OVERFLOW = 2'b10} huff_err_t;
   function automatic int clog2(input int v);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
   function automatic int idx_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction
   function automatic int code_bytes(input int max_len);
      return (max_len + 7) / 8;
   endfunction
endpackage

// File: rtl/huffman_min2.sv
// huffman_min2: registered tracker of the two smallest (freq, index) pairs seen since clear.
// Nodes arrive in ascending index order, so strict less-than keeps the lower index on ties.
module huffman_min2 #(
   parameter int SW = 8,
   parameter int IW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic [IW-1:0] i_idx,
   input  logic [SW-1:0] i_freq,
   output logic [IW-1:0] o_idx1,
   output logic [SW-1:0] o_freq1,
   output logic [IW-1:0] o_idx2,
   output logic [SW-1:0] o_freq2
);
   logic          r_v1, r_v2;
   logic [IW-1:0] r_i1, r_i2;
   logic [SW-1:0] r_f1, r_f2;
   assign o_idx1  = r_i1;
   assign o_freq1 = r_f1;
   assign o_idx2  = r_i2;
   assign o_freq2 = r_f2;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_i1 <= '0;
         r_i2 <= '0;
         r_f1 <= '0;
         r_f2 <= '0;
      end else if (i_clr) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else if (i_en) begin
         if (!r_v1 || i_freq < r_f1) begin
            r_i2 <= r_i1;
            r_f2 <= r_f1;
            r_v2 <= r_v1;
            r_i1 <= i_idx;
            r_f1 <= i_freq;
            r_v1 <= 1'b1;
         end else if (!r_v2 || i_freq < r_f2) begin
            r_i2 <= i_idx;
            r_f2 <= i_freq;
            r_v2 <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/huffman_codegen.sv
// huffman_codegen: loads a frequency table from byte memory, builds the Huffman tree,
// walks each leaf to the root and writes {length, right-aligned code bytes} records back.
module huffman_codegen
   import huffman_pkg::*;
#(
   parameter int          NSYM       = 45,
   parameter int          FREQ_BYTES = 2,
   parameter int          MAX_LEN    = 16,
   parameter logic [15:0] FREQ_BASE  = 16'h0000,
   parameter logic [15:0] CODE_BASE  = 16'h005A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        huff_start,
   input  logic [7:0]  data_read,
   output logic        read,
   output logic        write,
   output logic [15:0] addr,
   output logic [7:0]  data,
   output logic        huff_done,
   output logic [1:0]  huff_err
);
   localparam int CB  = code_bytes(MAX_LEN);
   localparam int CBW = 8 * CB;
   localparam int NN  = 2 * NSYM - 1;
   localparam int SW  = 8 * FREQ_BYTES + clog2(NSYM);
   localparam int IW  = idx_w(NN);
   localparam int NB  = NSYM * FREQ_BYTES;
   localparam int CW  = idx_w(NB + 1);
   localparam int BW  = idx_w(FREQ_BYTES);
   state_t         r_state;
   huff_err_t      r_err;
   logic [SW-1:0]  r_freq [NN];
   logic [IW-1:0]  r_par [NN];
   logic [NN-1:0]  r_act, r_rt;
   logic [IW-1:0]  r_next, r_nact, r_idx, r_root, r_cur, r_sym, r_lsym;
   logic [CW-1:0]  r_cnt;
   logic [BW-1:0]  r_lb;
   logic [7:0]     r_len, r_data;
   logic [CBW-1:0] r_code;
   logic [2:0]     r_k;
   logic [15:0]    r_wa, r_addr;
   logic           r_single, r_start_q, r_read, r_write, r_done;
   logic           w_newact, w_go, w_f0, w_last_sym;
   logic [IW-1:0]  w_na, w_m1, w_m2;
   logic [SW-1:0]  w_f1, w_f2;
   logic [7:0]     w_nd;
   assign w_newact   = !r_act[r_lsym] && (data_read != 8'd0);
   assign w_na       = r_nact + IW'(w_newact);
   assign w_go       = huff_start && (r_state == S_IDLE || !r_start_q);
   assign w_f0       = r_freq[r_sym] == '0;
   assign w_nd       = r_len + 8'd1;
   assign w_last_sym = r_sym == IW'(NSYM - 1);
   assign read       = r_read;
   assign write      = r_write;
   assign addr       = r_addr;
   assign data       = r_data;
   assign huff_done  = r_done;
   assign huff_err   = r_err;
   huffman_min2 #(.SW(SW), .IW(IW)) u_min2 (
      .clk(clk), .rst(rst), .i_clr(r_state != S_SCAN), .i_en(r_act[r_idx]),
      .i_idx(r_idx), .i_freq(r_freq[r_idx]),
      .o_idx1(w_m1), .o_freq1(w_f1), .o_idx2(w_m2), .o_freq2(w_f2)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NN; i++) begin
            r_freq[i] <= '0;
            r_par[i]  <= '0;
         end
         r_act     <= '0;
         r_rt      <= '0;
         r_state   <= S_IDLE;
         r_err     <= ERR_OK;
         r_next    <= IW'(NSYM);
         r_nact    <= '0;
         r_idx     <= '0;
         r_root    <= '0;
         r_cur     <= '0;
         r_sym     <= '0;
         r_lsym    <= '0;
         r_cnt     <= '0;
         r_lb      <= '0;
         r_len     <= '0;
         r_data    <= '0;
         r_code    <= '0;
         r_k       <= '0;
         r_wa      <= CODE_BASE;
         r_addr    <= '0;
         r_single  <= 1'b0;
         r_start_q <= 1'b0;
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_start_q <= huff_start;
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: if (w_go) begin
               for (int i = 0; i < NN; i++) begin
                  r_freq[i] <= '0;
                  r_par[i]  <= '0;
               end
               r_act    <= '0;
               r_rt     <= '0;
               r_next   <= IW'(NSYM);
               r_nact   <= '0;
               r_cur    <= '0;
               r_sym    <= '0;
               r_lsym   <= '0;
               r_cnt    <= '0;
               r_lb     <= '0;
               r_len    <= '0;
               r_code   <= '0;
               r_wa     <= CODE_BASE;
               r_single <= 1'b0;
               r_done   <= 1'b0;
               r_err    <= ERR_OK;
               r_read   <= 1'b1;
               r_addr   <= FREQ_BASE;
               r_state  <= S_LOAD;
            end
            S_LOAD: begin
               r_cnt  <= r_cnt + 1'b1;
               r_read <= int'(r_cnt) + 1 < NB;
               r_addr <= FREQ_BASE + 16'(r_cnt) + 16'd1;
               // each byte returns one cycle after its read, so capture lags issue by one
               if (r_cnt != '0) begin
                  r_freq[r_lsym] <= {r_freq[r_lsym][SW-9:0], data_read};
                  if (w_newact) r_act[r_lsym] <= 1'b1;
                  r_nact <= w_na;
                  r_lb   <= (r_lb == BW'(FREQ_BYTES - 1)) ? '0 : r_lb + 1'b1;
                  if (r_lb == BW'(FREQ_BYTES - 1)) r_lsym <= r_lsym + 1'b1;
                  if (int'(r_cnt) == NB) begin
                     if (w_na == '0) begin
                        r_done  <= 1'b1;
                        r_err   <= ERR_EMPTY;
                        r_state <= S_DONE;
                     end else if (w_na == IW'(1)) begin
                        r_single <= 1'b1;
                        r_state  <= S_WALK;
                     end else begin
                        r_idx   <= '0;
                        r_state <= S_SCAN;
                     end
                  end
               end
            end
            S_SCAN: begin
               if (r_idx == r_next - 1'b1) r_state <= S_MERGE;
               else r_idx <= r_idx + 1'b1;
            end
            S_MERGE: begin
               r_freq[r_next] <= w_f1 + w_f2;
               r_act[w_m1]    <= 1'b0;
               r_act[w_m2]    <= 1'b0;
               r_act[r_next]  <= 1'b1;
               r_par[w_m1]    <= r_next;
               r_par[w_m2]    <= r_next;
               r_rt[w_m2]     <= 1'b1;
               r_root         <= r_next;
               r_next         <= r_next + 1'b1;
               r_nact         <= r_nact - 1'b1;
               r_idx          <= '0;
               r_state        <= (r_nact == IW'(2)) ? S_WALK : S_SCAN;
            end
            S_WALK: begin
               if (!w_f0 && !r_single && w_nd > 8'(MAX_LEN)) begin
                  r_done  <= 1'b1;
                  r_err   <= ERR_OVERFLOW;
                  r_state <= S_DONE;
               end else if (w_f0 || r_single || r_par[r_cur] == r_root) begin
                  r_write <= 1'b1;
                  r_addr  <= r_wa;
                  r_wa    <= r_wa + 16'd1;
                  r_data  <= w_f0 ? 8'd0 : (r_single ? 8'd1 : w_nd);
                  r_k     <= '0;
                  r_state <= S_WR;
               end
               // step i's branch bit lands at code bit i, so the leaf branch is the LSB
               if (!w_f0 && !r_single) begin
                  r_code <= r_code | (CBW'(r_rt[r_cur]) << r_len);
                  r_len  <= w_nd;
                  r_cur  <= r_par[r_cur];
               end
            end
            S_WR: begin
               if (r_k < 3'(CB)) begin
                  r_write <= 1'b1;
                  r_addr  <= r_wa;
                  r_wa    <= r_wa + 16'd1;
                  r_data  <= r_code[CBW-1 -: 8];
                  r_code  <= r_code << 8;
                  r_k     <= r_k + 1'b1;
               end else if (w_last_sym) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_sym   <= r_sym + 1'b1;
                  r_cur   <= r_sym + 1'b1;
                  r_len   <= '0;
                  r_state <= S_WALK;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_huffman_codegen.sv
// tb_huffman_codegen: directed scenarios for the Huffman code generator on a 4-symbol alphabet.
module tb_huffman_codegen;
   logic        clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
   logic [7:0]  rd_a = 8'h00, rd_b = 8'h00;
   logic        read_a, write_a, done_a, read_b, write_b, done_b;
   logic [15:0] addr_a, addr_b;
   logic [7:0]  data_a, data_b;
   logic [1:0]  err_a, err_b;
   logic [7:0]  mem [16];
   logic [23:0] wq [$];
   logic [15:0] rq [$];
   int          checks = 0, failures = 0, cyc = 0, last_wr = 0, dcyc = 0;
   bit          both = 1'b0;

   always #5 clk = ~clk;

   huffman_codegen #(.NSYM(4), .FREQ_BYTES(2), .MAX_LEN(8), .FREQ_BASE(16'h0000), .CODE_BASE(16'h0100)) dut_a (
      .clk(clk), .rst(rst), .huff_start(start_a), .data_read(rd_a), .read(read_a), .write(write_a),
      .addr(addr_a), .data(data_a), .huff_done(done_a), .huff_err(err_a)
   );
   huffman_codegen #(.NSYM(4), .FREQ_BYTES(2), .MAX_LEN(2), .FREQ_BASE(16'h0000), .CODE_BASE(16'h0100)) dut_b (
      .clk(clk), .rst(rst), .huff_start(start_b), .data_read(rd_b), .read(read_b), .write(write_b),
      .addr(addr_b), .data(data_b), .huff_done(done_b), .huff_err(err_b)
   );

   always @(posedge clk) begin
      cyc++;
      if (read_a) rd_a <= (addr_a < 16'd16) ? mem[addr_a[3:0]] : 8'h00;
      if (read_b) rd_b <= (addr_b < 16'd16) ? mem[addr_b[3:0]] : 8'h00;
      if (read_a) rq.push_back(addr_a);
      if (read_b) rq.push_back(addr_b);
      if (write_a) begin
         wq.push_back({addr_a, data_a});
         last_wr = cyc;
      end
      if (write_b) wq.push_back({addr_b, data_b});
      if ((read_a && write_a) || (read_b && write_b)) both = 1'b1;
   end

   task automatic load(input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2, input logic [15:0] f3);
      {mem[0], mem[1]} = f0;
      {mem[2], mem[3]} = f1;
      {mem[4], mem[5]} = f2;
      {mem[6], mem[7]} = f3;
      for (int i = 8; i < 16; i++) mem[i] = 8'h00;
   endtask

   task automatic run(input bit b, output int n);
      wq.delete();
      rq.delete();
      start_a = !b;
      start_b = b;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(b ? done_b : done_a) && n < 1000);
      dcyc = cyc;
      checks++;
      if (n >= 1000) begin
         failures++;
         $display("FAIL run_timeout got no huff_done after %0d cycles want huff_done", n);
      end
      start_a = 1'b0;
      start_b = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #2;
      checks++;
      if ({read_a, write_a, done_a, addr_a, data_a, err_a} !== 29'd0) begin
         failures++;
         $display("FAIL reset_a got %h want 0", {read_a, write_a, done_a, addr_a, data_a, err_a});
      end
      checks++;
      if ({read_b, write_b, done_b, addr_b, data_b, err_b} !== 29'd0) begin
         failures++;
         $display("FAIL reset_b got %h want 0", {read_b, write_b, done_b, addr_b, data_b, err_b});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_balanced;
      logic [23:0] exp [8] = '{24'h010002, 24'h010100, 24'h010202, 24'h010301,
                               24'h010402, 24'h010502, 24'h010602, 24'h010703};
      int n;
      load(16'd5, 16'd9, 16'd12, 16'd13);
      run(1'b0, n);
      checks++;
      if (rq.size() !== 8) begin
         failures++;
         $display("FAIL bal_read_count got %0d want 8", rq.size());
      end
      for (int i = 0; i < 8 && i < rq.size(); i++) begin
         checks++;
         if (rq[i] !== 16'(i)) begin
            failures++;
            $display("FAIL bal_read_addr[%0d] got %h want %h", i, rq[i], 16'(i));
         end
      end
      checks++;
      if (wq.size() !== 8) begin
         failures++;
         $display("FAIL bal_write_count got %0d want 8", wq.size());
      end
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== exp[i]) begin
            failures++;
            $display("FAIL bal_write[%0d] got %h want %h", i, wq[i], exp[i]);
         end
      end
      checks++;
      if (err_a !== 2'b00 || done_a !== 1'b1) begin
         failures++;
         $display("FAIL bal_status got done=%b err=%b want done=1 err=00", done_a, err_a);
      end
      checks++;
      if (dcyc !== last_wr) begin
         failures++;
         $display("FAIL bal_done_timing got done at %0d want %0d", dcyc, last_wr);
      end
   endtask

   task automatic test_tiebreak;
      logic [23:0] exp [8] = '{24'h010003, 24'h010106, 24'h010203, 24'h010307,
                               24'h010402, 24'h010502, 24'h010601, 24'h010700};
      int n;
      load(16'd1, 16'd1, 16'd2, 16'd4);
      run(1'b0, n);
      checks++;
      if (wq.size() !== 8) begin
         failures++;
         $display("FAIL tie_write_count got %0d want 8", wq.size());
      end
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== exp[i]) begin
            failures++;
            $display("FAIL tie_write[%0d] got %h want %h", i, wq[i], exp[i]);
         end
      end
      checks++;
      if (err_a !== 2'b00) begin
         failures++;
         $display("FAIL tie_err got %b want 00", err_a);
      end
   endtask

   task automatic test_single;
      logic [23:0] exp [8] = '{24'h010000, 24'h010100, 24'h010201, 24'h010300,
                               24'h010400, 24'h010500, 24'h010600, 24'h010700};
      int n;
      load(16'd0, 16'd7, 16'd0, 16'd0);
      run(1'b0, n);
      checks++;
      if (wq.size() !== 8) begin
         failures++;
         $display("FAIL single_write_count got %0d want 8", wq.size());
      end
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== exp[i]) begin
            failures++;
            $display("FAIL single_write[%0d] got %h want %h", i, wq[i], exp[i]);
         end
      end
      checks++;
      if (err_a !== 2'b00) begin
         failures++;
         $display("FAIL single_err got %b want 00", err_a);
      end
   endtask

   task automatic test_empty;
      int n;
      load(16'd0, 16'd0, 16'd0, 16'd0);
      run(1'b0, n);
      checks++;
      if (n !== 10) begin
         failures++;
         $display("FAIL empty_latency got %0d want 10", n);
      end
      checks++;
      if (wq.size() !== 0) begin
         failures++;
         $display("FAIL empty_write_count got %0d want 0", wq.size());
      end
      checks++;
      if (err_a !== 2'b01 || done_a !== 1'b1) begin
         failures++;
         $display("FAIL empty_status got done=%b err=%b want done=1 err=01", done_a, err_a);
      end
   endtask

   task automatic test_overflow;
      int n;
      load(16'd1, 16'd1, 16'd2, 16'd4);
      run(1'b1, n);
      checks++;
      if (wq.size() !== 0) begin
         failures++;
         $display("FAIL ovf_write_count got %0d want 0", wq.size());
      end
      checks++;
      if (err_b !== 2'b10 || done_b !== 1'b1) begin
         failures++;
         $display("FAIL ovf_status got done=%b err=%b want done=1 err=10", done_b, err_b);
      end
   endtask

   task automatic test_hold;
      int n = 0;
      load(16'd0, 16'd7, 16'd0, 16'd0);
      start_a = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done_a && n < 1000);
      checks++;
      if (n >= 1000) begin
         failures++;
         $display("FAIL hold_timeout got no huff_done after %0d cycles want huff_done", n);
      end
      rq.delete();
      wq.delete();
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (rq.size() !== 0 || wq.size() !== 0 || done_a !== 1'b1) begin
         failures++;
         $display("FAIL hold_no_restart got reads=%0d writes=%0d done=%b want 0 0 1", rq.size(), wq.size(), done_a);
      end
      start_a = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_scan;
      logic [23:0] exp [8] = '{24'h010002, 24'h010100, 24'h010202, 24'h010301,
                               24'h010402, 24'h010502, 24'h010602, 24'h010703};
      int n;
      load(16'd5, 16'd9, 16'd12, 16'd13);
      wq.delete();
      start_a = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({read_a, write_a, done_a, addr_a, data_a, err_a} !== 29'd0 || wq.size() !== 0) begin
         failures++;
         $display("FAIL midscan_reset got %h writes=%0d want 0 writes=0", {read_a, write_a, done_a, addr_a, data_a, err_a}, wq.size());
      end
      start_a = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run(1'b0, n);
      checks++;
      if (wq.size() !== 8) begin
         failures++;
         $display("FAIL midscan_write_count got %0d want 8", wq.size());
      end
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== exp[i]) begin
            failures++;
            $display("FAIL midscan_write[%0d] got %h want %h", i, wq[i], exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_balanced();
      test_tiebreak();
      test_single();
      test_empty();
      test_overflow();
      test_hold();
      test_reset_mid_scan();
      checks++;
      if (both) begin
         failures++;
         $display("FAIL strobe_overlap got read&write=1 want 0");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
